// File: rtl/lc3_ctrl_pkg.sv
// Shared LC3 control types: opcode and memory-state encodings plus opcode class helpers.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
    OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_READ  = 2'b00,
    MEM_IND   = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_IDLE  = 2'b11
  } mem_state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT};
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return op inside {OP_BR, OP_JMP};
  endfunction

  // Instructions whose IR[8:6] names a source register.
  function automatic logic reads_sr1(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer: walks read / indirect / write phases and flags the
// cycle the pipeline resumes, remembering whether that access was a load.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       exec_en,
  input  logic [3:0] op,
  input  logic       complete_data,
  output mem_state_t mem_state,
  output logic       stall,
  output logic       exit_cyc,
  output logic       exit_load
);

  mem_state_t state, state_nxt;
  logic       ind_ld, ind_ld_nxt;
  logic       exit_nxt, exit_load_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MEM_IDLE;
      ind_ld    <= 1'b0;
      exit_cyc  <= 1'b0;
      exit_load <= 1'b0;
    end else begin
      state     <= state_nxt;
      ind_ld    <= ind_ld_nxt;
      exit_cyc  <= exit_nxt;
      exit_load <= exit_load_nxt;
    end
  end

  // The resume cycle still shows the finished ld/st in execute, so it must not restart.
  always_comb begin
    state_nxt     = state;
    ind_ld_nxt    = ind_ld;
    exit_nxt      = 1'b0;
    exit_load_nxt = exit_load;
    case (state)
      MEM_IDLE: if (exec_en && !exit_cyc) begin
        if (op == OP_LD || op == OP_LDR) state_nxt = MEM_READ;
        else if (op == OP_ST || op == OP_STR) state_nxt = MEM_WRITE;
        else if (op == OP_LDI || op == OP_STI) begin
          state_nxt  = MEM_IND;
          ind_ld_nxt = (op == OP_LDI);
        end
      end
      MEM_IND: if (complete_data) state_nxt = ind_ld ? MEM_READ : MEM_WRITE;
      MEM_READ, MEM_WRITE: if (complete_data) begin
        state_nxt     = MEM_IDLE;
        exit_nxt      = 1'b1;
        exit_load_nxt = (state == MEM_READ);
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  assign mem_state = state;
  assign stall     = (state != MEM_IDLE);

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC3 pipeline sequencer: fill shifter, memory stalls, branch resolution/squash and
// operand bypass selects around the execute stage.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int DW        = 16,
  parameter int BR_SQUASH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          complete_data,
  input  logic          complete_instr,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] IR_Exec,
  input  logic [DW-1:0] IMem_dout,
  input  logic [2:0]    NZP,
  input  logic [2:0]    psr,
  output logic          enable_fetch,
  output logic          enable_decode,
  output logic          enable_execute,
  output logic          enable_writeback,
  output logic          enable_updatePC,
  output logic          br_taken,
  output logic [1:0]    mem_state,
  output logic          bypass_alu_1,
  output logic          bypass_alu_2,
  output logic          bypass_mem_1,
  output logic          bypass_mem_2
);

  localparam int SQW = $clog2(BR_SQUASH + 2);

  mem_state_t     ms;
  logic [2:0]     vld_pipe;
  logic [SQW-1:0] sq_cnt;
  logic           br_pend, stall, exit_cyc, exit_load;
  logic           run, sq_de, resolve, sr1_hit, sr2_hit;
  logic [3:0]     op_ex, op_id, op_if;
  logic [2:0]     prev;
  logic           unused_bits;

  assign op_ex = IR_Exec[DW-1:DW-4];
  assign op_id = IR[DW-1:DW-4];
  assign op_if = IMem_dout[DW-1:DW-4];
  assign prev  = IR_Exec[11:9];
  assign unused_bits = ^{IR[4:3], IR_Exec[8:0], IMem_dout[DW-5:0]};

  lc3_mem_fsm u_mem_fsm (
    .clock         (clock),
    .reset         (reset),
    .exec_en       (enable_execute),
    .op            (op_ex),
    .complete_data (complete_data),
    .mem_state     (ms),
    .stall         (stall),
    .exit_cyc      (exit_cyc),
    .exit_load     (exit_load)
  );

  // sq_cnt covers the writeback window; decode/execute reopen one cycle earlier.
  assign run   = !reset && !stall;
  assign sq_de = sq_cnt > SQW'(1);

  assign enable_execute   = run && vld_pipe[1] && !sq_de;
  assign resolve          = enable_execute && is_ctrl(op_ex);
  assign enable_decode    = run && vld_pipe[0] && !sq_de && complete_instr;
  assign enable_fetch     = run && (resolve || (!br_pend && complete_instr));
  assign enable_updatePC  = enable_fetch;
  assign enable_writeback = run && (exit_cyc ? exit_load : (vld_pipe[2] && sq_cnt == '0));
  assign br_taken         = resolve && (op_ex == OP_JMP || |(NZP & psr));
  assign mem_state        = ms;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      sq_cnt   <= '0;
      br_pend  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      if (!stall) begin
        if (resolve)              sq_cnt <= SQW'(BR_SQUASH + 1);
        else if (sq_cnt != '0)    sq_cnt <= sq_cnt - 1'b1;
      end
      if (resolve)                              br_pend <= 1'b0;
      else if (enable_fetch && is_ctrl(op_if))  br_pend <= 1'b1;
    end
  end

  assign sr1_hit = reads_sr1(op_id) && IR[8:6] == prev;
  assign sr2_hit = ((op_id == OP_ADD || op_id == OP_AND) && !IR[5] && IR[2:0] == prev)
                || (is_store(op_id) && IR[11:9] == prev);

  assign bypass_alu_1 = run && is_alu(op_ex)  && sr1_hit;
  assign bypass_alu_2 = run && is_alu(op_ex)  && sr2_hit;
  assign bypass_mem_1 = run && is_load(op_ex) && sr1_hit;
  assign bypass_mem_2 = run && is_load(op_ex) && sr2_hit;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed scenarios plus randomized traffic checked against a queue/counter model of the controller.
module tb_lc3_pipe_controller;

  localparam int BR_SQUASH = 2;

  logic        clock = 1'b0, reset = 1'b1, complete_data = 1'b0, complete_instr = 1'b1;
  logic [15:0] IR = 16'h0000, IR_Exec = 16'h1000, IMem_dout = 16'h1000;
  logic [2:0]  NZP = 3'b000, psr = 3'b000;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, br_taken;
  logic [1:0]  mem_state;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  int          nchk = 0, nfail = 0;

  always #5 clock = ~clock;

  lc3_pipe_controller #(.DW(16), .BR_SQUASH(BR_SQUASH)) dut (
    .clock(clock), .reset(reset), .complete_data(complete_data), .complete_instr(complete_instr),
    .IR(IR), .IR_Exec(IR_Exec), .IMem_dout(IMem_dout), .NZP(NZP), .psr(psr),
    .enable_fetch(enable_fetch), .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .enable_updatePC(enable_updatePC), .br_taken(br_taken),
    .mem_state(mem_state), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2)
  );

  typedef struct packed {
    logic f, d, e, w, u, bt;
    logic [1:0] ms;
    logic a1, a2, m1, m2;
  } exp_t;

  // Reference state: edges since reset, pending memory phases, squash window, fetch hold.
  int since_rst = 0;
  int phases[$];
  bit exit_pend = 0, exit_wb = 0, br_pend = 0;
  int squash = 0;

  function automatic exp_t model_out();
    exp_t x;
    int oe, oi;
    bit stl, ex, res, s1, s2, alu_ex, ld_ex;
    oe  = int'(IR_Exec[15:12]);
    oi  = int'(IR[15:12]);
    stl = phases.size() != 0;
    x   = '0;
    x.ms = stl ? 2'(phases[0]) : 2'b11;
    if (!reset && !stl) begin
      ex   = since_rst >= 2 && squash < 2;
      res  = ex && (oe == 0 || oe == 12);
      x.e  = ex;
      x.d  = since_rst >= 1 && squash < 2 && complete_instr;
      x.f  = res || (!br_pend && complete_instr);
      x.u  = x.f;
      x.w  = exit_pend ? exit_wb : (since_rst >= 3 && squash == 0);
      x.bt = res && (oe == 12 || (NZP & psr) != 3'b000);
      s1 = (oi inside {1, 5, 9, 6, 7, 12}) && IR[8:6] == IR_Exec[11:9];
      s2 = ((oi == 1 || oi == 5) && !IR[5] && IR[2:0] == IR_Exec[11:9])
        || ((oi inside {3, 7, 11}) && IR[11:9] == IR_Exec[11:9]);
      alu_ex = oe inside {1, 5, 9};
      ld_ex  = oe inside {2, 6, 10};
      x.a1 = alu_ex && s1;
      x.a2 = alu_ex && s2;
      x.m1 = ld_ex && s1;
      x.m2 = ld_ex && s2;
    end
    return x;
  endfunction

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic tick();
    exp_t x;
    int   oe, p;
    bit   res, nexit;
    x  = model_out();
    oe = int'(IR_Exec[15:12]);
    @(posedge clock);
    if (reset) begin
      since_rst = 0; phases.delete(); exit_pend = 0; exit_wb = 0; squash = 0; br_pend = 0;
    end else begin
      nexit = 0;
      if (since_rst < 3) since_rst++;
      if (phases.size() != 0) begin
        if (complete_data) begin
          p = phases.pop_front();
          if (phases.size() == 0) begin nexit = 1; exit_wb = (p == 0); end
        end
      end else begin
        if (x.e && !exit_pend)
          case (oe)
            2, 6:    phases = {0};
            3, 7:    phases = {2};
            10:      phases = {1, 0};
            11:      phases = {1, 2};
            default: ;
          endcase
        res = x.e && (oe == 0 || oe == 12);
        if (res) squash = BR_SQUASH + 1;
        else if (squash > 0) squash--;
        if (res) br_pend = 0;
        else if (x.f && complete_instr && (IMem_dout[15:12] == 4'h0 || IMem_dout[15:12] == 4'hC)) br_pend = 1;
      end
      exit_pend = nexit;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] want [4] = '{5'b10001, 5'b11001, 5'b11101, 5'b11111};
    reset = 1; complete_instr = 1; complete_data = 0;
    IR_Exec = 16'h1000; IR = 16'h0000; IMem_dout = 16'h1000;
    repeat (3) tick();
    #1;
    nchk++;
    if ({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, br_taken,
         mem_state, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} !== 12'b000000_11_0000) begin
      nfail++; $display("FAIL reset_state: got f%b d%b e%b w%b u%b bt%b ms%b, want all 0 ms 11",
        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, br_taken, mem_state);
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++;
      if ({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC} !== want[i]
          || mem_state !== 2'b11) begin
        nfail++; $display("FAIL fill_cycle%0d: got fdewu=%b ms=%b, want %b ms=11", i + 1,
          {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}, mem_state, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [15:0] ex_t [5] = '{16'h1260, 16'h1460, 16'h2200, 16'h2200, 16'h1260};
    logic [15:0] id_t [5] = '{16'h1441, 16'h1441, 16'h1441, 16'h1461, 16'h7240};
    logic [3:0]  bp_t [5] = '{4'b1100, 4'b0000, 4'b0011, 4'b0010, 4'b1100};
    for (int i = 0; i < 5; i++) begin
      IR_Exec = ex_t[i]; IR = id_t[i];
      #1;
      nchk++;
      if ({bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} !== bp_t[i]) begin
        nfail++; $display("FAIL bypass%0d: got a1a2m1m2=%b, want %b", i,
          {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}, bp_t[i]);
      end
    end
    IR_Exec = 16'h1000; IR = 16'h0000;
    #1;
  endtask

  task automatic test_ldi();
    logic       cd [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] mx [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    IR_Exec = 16'hA200; complete_data = 0;
    #1;
    nchk++;
    if ({mem_state, enable_execute} !== 3'b111) begin
      nfail++; $display("FAIL ldi_issue: got ms=%b e=%b, want ms=11 e=1", mem_state, enable_execute);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      complete_data = cd[i];
      #1;
      nchk++;
      if ({mem_state, enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}
          !== {mx[i], 5'b00000}) begin
        nfail++; $display("FAIL ldi_stall%0d: got ms=%b fdewu=%b, want ms=%b fdewu=00000", i, mem_state,
          {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}, mx[i]);
      end
      tick();
    end
    complete_data = 0;
    #1;
    nchk++;
    if ({mem_state, enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC} !== 7'b11_11111) begin
      nfail++; $display("FAIL ldi_exit: got ms=%b fdewu=%b, want ms=11 fdewu=11111", mem_state,
        {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC});
    end
    tick();
    IR_Exec = 16'h1000;
    #1;
    nchk++;
    if (mem_state !== 2'b11) begin
      nfail++; $display("FAIL ldi_no_restart: got ms=%b, want 11", mem_state);
    end
  endtask

  task automatic test_str();
    IR_Exec = 16'h7240; complete_data = 0;
    #1;
    nchk++;
    if ({mem_state, enable_execute} !== 3'b111) begin
      nfail++; $display("FAIL str_issue: got ms=%b e=%b, want ms=11 e=1", mem_state, enable_execute);
    end
    tick();
    complete_data = 1;
    #1;
    nchk++;
    if ({mem_state, enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC} !== 7'b10_00000) begin
      nfail++; $display("FAIL str_write: got ms=%b fdewu=%b, want ms=10 fdewu=00000", mem_state,
        {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC});
    end
    tick();
    complete_data = 0;
    #1;
    nchk++;
    if ({mem_state, enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC} !== 7'b11_11101) begin
      nfail++; $display("FAIL str_exit: got ms=%b fdewu=%b, want ms=11 fdewu=11101", mem_state,
        {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC});
    end
    tick();
    IR_Exec = 16'h1000;
  endtask

  task automatic test_branch();
    logic [2:0] sq [4] = '{3'b000, 3'b000, 3'b110, 3'b111};
    logic bt_w;
    NZP = 3'b010;
    for (int k = 0; k < 2; k++) begin
      psr  = (k == 0) ? 3'b010 : 3'b100;
      bt_w = (k == 0);
      IR_Exec = 16'h0400;
      #1;
      nchk++;
      if ({br_taken, enable_execute, enable_fetch, enable_updatePC} !== {bt_w, 3'b111}) begin
        nfail++; $display("FAIL branch%0d_resolve: got bt=%b e=%b f=%b u=%b, want bt=%b e=f=u=1", k,
          br_taken, enable_execute, enable_fetch, enable_updatePC, bt_w);
      end
      tick();
      IR_Exec = 16'h1000;
      for (int j = 0; j < 4; j++) begin
        #1;
        nchk++;
        if ({enable_decode, enable_execute, enable_writeback} !== sq[j]) begin
          nfail++; $display("FAIL branch%0d_squash%0d: got dew=%b, want %b", k, j,
            {enable_decode, enable_execute, enable_writeback}, sq[j]);
        end
        tick();
      end
    end
  endtask

  task automatic test_hazard();
    IMem_dout = 16'h0E00;
    #1;
    nchk++;
    if ({enable_fetch, enable_updatePC} !== 2'b11) begin
      nfail++; $display("FAIL hazard_fetch: got fu=%b, want 11", {enable_fetch, enable_updatePC});
    end
    tick();
    IMem_dout = 16'h1000;
    for (int i = 0; i < 2; i++) begin
      #1;
      nchk++;
      if ({enable_fetch, enable_updatePC} !== 2'b00) begin
        nfail++; $display("FAIL hazard_hold%0d: got fu=%b, want 00", i, {enable_fetch, enable_updatePC});
      end
      tick();
    end
    IR_Exec = 16'hC1C0;
    #1;
    nchk++;
    if ({br_taken, enable_fetch, enable_updatePC} !== 3'b111) begin
      nfail++; $display("FAIL hazard_jmp: got bt/f/u=%b, want 111", {br_taken, enable_fetch, enable_updatePC});
    end
    tick();
    IR_Exec = 16'h1000;
    repeat (4) tick();
    complete_instr = 0;
    #1;
    nchk++;
    if ({enable_fetch, enable_decode, enable_execute} !== 3'b001) begin
      nfail++; $display("FAIL instr_wait: got fde=%b, want 001", {enable_fetch, enable_decode, enable_execute});
    end
    tick();
    complete_instr = 1;
  endtask

  task automatic test_reset_mid();
    IR_Exec = 16'hA200; complete_data = 0;
    #1;
    tick();
    IR_Exec = 16'h1000;
    #1;
    nchk++;
    if (mem_state !== 2'b01) begin
      nfail++; $display("FAIL rmid_ind: got ms=%b, want 01", mem_state);
    end
    reset = 1;
    tick();
    #1;
    nchk++;
    if ({mem_state, enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC} !== 7'b11_00000) begin
      nfail++; $display("FAIL rmid_reset: got ms=%b fdewu=%b, want ms=11 fdewu=00000", mem_state,
        {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC});
    end
    reset = 0; complete_data = 1;
    #1;
    nchk++;
    if ({mem_state, enable_fetch, enable_execute} !== 4'b1110) begin
      nfail++; $display("FAIL rmid_release: got ms=%b f=%b e=%b, want ms=11 f=1 e=0", mem_state,
        enable_fetch, enable_execute);
    end
    tick();
    complete_data = 0;
    #1;
    nchk++;
    if (mem_state !== 2'b11) begin
      nfail++; $display("FAIL rmid_ignored: got ms=%b, want 11", mem_state);
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    exp_t e, a;
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      complete_data  = ($urandom_range(0, 2) == 0);
      complete_instr = ($urandom_range(0, 7) != 0);
      IR_Exec        = 16'($urandom);
      IR             = 16'($urandom);
      IMem_dout      = ($urandom_range(0, 5) == 0) ? {4'($urandom_range(0, 1) * 12), 12'($urandom)}
                                                   : (16'h1000 | 16'($urandom_range(0, 4095)));
      NZP            = 3'($urandom);
      psr            = 3'($urandom);
      #1;
      e = model_out();
      a = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, br_taken,
           mem_state, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
      nchk++;
      if (a !== e) begin
        nfail++; $display("FAIL random_cycle%0d: got %b, want %b (f d e w u bt ms a1 a2 m1 m2)", i, a, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ldi();
    test_str();
    test_branch();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
